// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file and its scoreboard.
// Optional same-cycle write-to-read bypass is enabled with `define REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue (ID), cleared at writeback (WB).
// With REGFILE_BYPASS_EN, a same-cycle write also hides the pending bit from readers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_WR-1:0]              we,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  w_addr,
  input  logic                           sb_set,
  input  logic [ADDR_W-1:0]              sb_addr,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  r_addr,
  output logic [NUM_RD-1:0]              rd_pending
);

  logic [NUM_REGS-1:0] pending;

  // Clears are applied first so a same-cycle set (younger producer) overrides them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j]) pending[w_addr[j]] <= 1'b0;
      end
      if (sb_set && (sb_addr != ADDR_W'(ZERO_REG))) pending[sb_addr] <= 1'b1;
    end
  end

  always_comb begin
    rd_pending = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_pending[i] = pending[r_addr[i]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && (w_addr[j] == r_addr[i]) && !(sb_set && (sb_addr == r_addr[i])))
          rd_pending[i] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with integrated pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_WR-1:0]              we,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  w_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  w_data,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  r_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  input  logic                           sb_set,
  input  logic [ADDR_W-1:0]              sb_addr,
  output logic [NUM_RD-1:0]              rd_pending
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Ports are applied in ascending order so the highest-index port wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && (w_addr[j] != ADDR_W'(ZERO_REG))) regs[w_addr[j]] <= w_data[j];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i] = regs[r_addr[i]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (rst_n && we[j] && (w_addr[j] == r_addr[i]) && (r_addr[i] != ADDR_W'(ZERO_REG)))
          rd_data[i] = w_data[j];
      end
`endif
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .w_addr     (w_addr),
    .sb_set     (sb_set),
    .sb_addr    (sb_addr),
    .r_addr     (r_addr),
    .rd_pending (rd_pending)
  );

endmodule
